// File: rtl/wb_gpio_bank_pkg.sv
// Shared widths, register offsets, bus payload type and helpers for the GPIO bank.
package wb_gpio_bank_pkg;

    localparam int unsigned WB_AW     = 32;
    localparam int unsigned WB_DW     = 32;
    localparam int unsigned WB_SW     = WB_DW / 8;

    // Each channel occupies a 0x20-byte window holding eight word registers.
    localparam int unsigned CH_STRIDE = 32;
    localparam int unsigned OFS_W     = 3;
    localparam int unsigned OFS_LSB   = 2;
    localparam int unsigned CH_IDX_W  = 3;
    localparam int unsigned CH_LSB    = OFS_LSB + OFS_W;
    localparam int unsigned MAX_CH    = 8;

    // Word offset within a channel window (byte offset / 4).
    typedef enum logic [OFS_W-1:0] {
        OFS_OUT  = 3'd0,
        OFS_DIR  = 3'd1,
        OFS_IN   = 3'd2,
        OFS_IEN  = 3'd3,
        OFS_EDGE = 3'd4,
        OFS_STAT = 3'd5,
        OFS_RSV6 = 3'd6,
        OFS_RSV7 = 3'd7
    } reg_ofs_e;

    // Wishbone request payload as seen by the slave.
    typedef struct packed {
        logic [WB_AW-1:0] adr;
        logic [WB_DW-1:0] dat;
        logic [WB_SW-1:0] sel;
        logic             we;
    } wb_req_t;

    // Expand byte-lane selects into a per-bit write mask.
    function automatic logic [WB_DW-1:0] lane_mask(input logic [WB_SW-1:0] sel);
        logic [WB_DW-1:0] m;
        m = '0;
        for (int b = 0; b < int'(WB_SW); b++) begin
            m[b*8 +: 8] = {8{sel[b]}};
        end
        return m;
    endfunction

endpackage

// File: rtl/wb_gpio_bank_channel.sv
// One GPIO channel: OUT/DIR/IEN/EDGE/STAT registers, input synchroniser,
// edge detection, write decode for its offsets and a read mux.
module wb_gpio_bank_channel
    import wb_gpio_bank_pkg::*;
#(
    parameter int unsigned CH_WIDTH = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                wr_en,
    input  reg_ofs_e            ofs,
    input  logic [WB_DW-1:0]    wr_dat,
    input  logic [WB_SW-1:0]    wr_sel,
    input  logic [CH_WIDTH-1:0] pad,
    output logic [CH_WIDTH-1:0] out_q,
    output logic [CH_WIDTH-1:0] dir_q,
    output logic [WB_DW-1:0]    rd_dat_c,
    output logic                irq_c
);

    logic [CH_WIDTH-1:0] ien_q;
    logic [CH_WIDTH-1:0] edge_q;
    logic [CH_WIDTH-1:0] stat_q;
    logic [CH_WIDTH-1:0] sync1_q;
    logic [CH_WIDTH-1:0] sync2_q;
    logic [CH_WIDTH-1:0] prev_q;

    logic [WB_DW-1:0]    lane_c;
    logic [CH_WIDTH-1:0] out_nxt_c;
    logic [CH_WIDTH-1:0] dir_nxt_c;
    logic [CH_WIDTH-1:0] ien_nxt_c;
    logic [CH_WIDTH-1:0] edge_nxt_c;
    logic [CH_WIDTH-1:0] stat_clr_c;
    logic [CH_WIDTH-1:0] rise_c;
    logic [CH_WIDTH-1:0] fall_c;
    logic [CH_WIDTH-1:0] stat_set_c;

    // Byte-lane merge of write data into a register; bits above CH_WIDTH are dropped.
    function automatic logic [CH_WIDTH-1:0] merge(
        input logic [CH_WIDTH-1:0] cur,
        input logic [WB_DW-1:0]    dat,
        input logic [WB_DW-1:0]    lane
    );
        return CH_WIDTH'((WB_DW'(cur) & ~lane) | (dat & lane));
    endfunction

    assign lane_c = lane_mask(wr_sel);

    // Write decode: next values for the rw registers and the W1C mask for STAT.
    always_comb begin
        out_nxt_c  = out_q;
        dir_nxt_c  = dir_q;
        ien_nxt_c  = ien_q;
        edge_nxt_c = edge_q;
        stat_clr_c = '0;
        if (wr_en) begin
            case (ofs)
                OFS_OUT:  out_nxt_c  = merge(out_q,  wr_dat, lane_c);
                OFS_DIR:  dir_nxt_c  = merge(dir_q,  wr_dat, lane_c);
                OFS_IEN:  ien_nxt_c  = merge(ien_q,  wr_dat, lane_c);
                OFS_EDGE: edge_nxt_c = merge(edge_q, wr_dat, lane_c);
                OFS_STAT: stat_clr_c = CH_WIDTH'(wr_dat & lane_c);
                default:  ;
            endcase
        end
    end

    // Edge events from the synchronised input, qualified by polarity and enable.
    always_comb begin
        rise_c     = sync2_q & ~prev_q;
        fall_c     = ~sync2_q & prev_q;
        stat_set_c = ((rise_c & edge_q) | (fall_c & ~edge_q)) & ien_q;
    end

    // Configuration registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q  <= '0;
            dir_q  <= '0;
            ien_q  <= '0;
            edge_q <= '0;
        end else begin
            out_q  <= out_nxt_c;
            dir_q  <= dir_nxt_c;
            ien_q  <= ien_nxt_c;
            edge_q <= edge_nxt_c;
        end
    end

    // Two-flop synchroniser followed by the previous-value register for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
            prev_q  <= '0;
        end else begin
            sync1_q <= pad;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    // Sticky status; a new event on the same bit as a W1C keeps the bit set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_q <= '0;
        end else begin
            stat_q <= (stat_q & ~stat_clr_c) | stat_set_c;
        end
    end

    // Read mux, zero-extended; reserved offsets read zero.
    always_comb begin
        rd_dat_c = '0;
        case (ofs)
            OFS_OUT:  rd_dat_c = WB_DW'(out_q);
            OFS_DIR:  rd_dat_c = WB_DW'(dir_q);
            OFS_IN:   rd_dat_c = WB_DW'(sync2_q);
            OFS_IEN:  rd_dat_c = WB_DW'(ien_q);
            OFS_EDGE: rd_dat_c = WB_DW'(edge_q);
            OFS_STAT: rd_dat_c = WB_DW'(stat_q);
            default:  rd_dat_c = '0;
        endcase
    end

    // Per-channel interrupt request before the bank-level register.
    always_comb begin
        irq_c = |(stat_q & ien_q);
    end

endmodule

// File: rtl/wb_gpio_bank.sv
// Wishbone slave GPIO bank: address decode, single-wait-state ack, read-data
// select across channels and the registered interrupt OR.
module wb_gpio_bank
    import wb_gpio_bank_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
    parameter int unsigned NUM_CH    = 4,
    parameter int unsigned CH_WIDTH  = 32
) (
    input  logic                       wb_clk_i,
    input  logic                       wb_rst_i,
    input  logic [WB_AW-1:0]           wb_adr_i,
    input  logic [WB_DW-1:0]           wb_dat_i,
    input  logic [WB_SW-1:0]           wb_sel_i,
    input  logic                       wb_we_i,
    input  logic                       wb_cyc_i,
    input  logic                       wb_stb_i,
    output logic [WB_DW-1:0]           wb_dat_o,
    output logic                       wb_ack_o,
    output logic                       hit_o,
    input  logic [NUM_CH*CH_WIDTH-1:0] gpio_i,
    output logic [NUM_CH*CH_WIDTH-1:0] gpio_o,
    output logic [NUM_CH*CH_WIDTH-1:0] gpio_oe,
    output logic                       irq_o
);

    localparam logic [WB_AW-1:0] WIN_SIZE = WB_AW'(NUM_CH * CH_STRIDE);

    wb_req_t             req_c;
    logic [WB_AW-1:0]    adr_rel_c;
    logic [CH_IDX_W-1:0] ch_idx_c;
    reg_ofs_e            ofs_c;
    logic                request_c;
    logic                wr_commit_c;
    logic                rd_launch_c;
    logic [WB_DW-1:0]    ch_rd_c [NUM_CH];
    logic [NUM_CH-1:0]   ch_irq_c;
    logic [WB_DW-1:0]    rd_sel_c;

    assign req_c = '{adr: wb_adr_i, dat: wb_dat_i, sel: wb_sel_i, we: wb_we_i};

    // Window decode; an address below the base wraps far above the window size.
    always_comb begin
        adr_rel_c = req_c.adr - BASE_ADDR;
        hit_o     = adr_rel_c < WIN_SIZE;
        ch_idx_c  = adr_rel_c[CH_LSB +: CH_IDX_W];
        ofs_c     = reg_ofs_e'(adr_rel_c[OFS_LSB +: OFS_W]);
    end

    // Request qualification: writes commit in the ack cycle, reads load on the first cycle.
    always_comb begin
        request_c   = wb_cyc_i & wb_stb_i & hit_o;
        wr_commit_c = request_c & wb_ack_o & req_c.we;
        rd_launch_c = request_c & ~wb_ack_o & ~req_c.we;
    end

    for (genvar c = 0; c < int'(NUM_CH); c++) begin : g_ch
        wb_gpio_bank_channel #(
            .CH_WIDTH (CH_WIDTH)
        ) u_ch (
            .clk      (wb_clk_i),
            .rst_n    (wb_rst_i),
            .wr_en    (wr_commit_c && (ch_idx_c == CH_IDX_W'(c))),
            .ofs      (ofs_c),
            .wr_dat   (req_c.dat),
            .wr_sel   (req_c.sel),
            .pad      (gpio_i[c*CH_WIDTH +: CH_WIDTH]),
            .out_q    (gpio_o[c*CH_WIDTH +: CH_WIDTH]),
            .dir_q    (gpio_oe[c*CH_WIDTH +: CH_WIDTH]),
            .rd_dat_c (ch_rd_c[c]),
            .irq_c    (ch_irq_c[c])
        );
    end

    // Select the addressed channel's read data.
    always_comb begin
        rd_sel_c = '0;
        for (int c = 0; c < int'(NUM_CH); c++) begin
            if (ch_idx_c == CH_IDX_W'(c)) begin
                rd_sel_c = ch_rd_c[c];
            end
        end
    end

    // Ack one cycle after the request; back-to-back requests are acked every other cycle.
    always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
        if (!wb_rst_i) begin
            wb_ack_o <= 1'b0;
        end else begin
            wb_ack_o <= request_c & ~wb_ack_o;
        end
    end

    // Read data register; holds its value when no read is launched.
    always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
        if (!wb_rst_i) begin
            wb_dat_o <= '0;
        end else if (rd_launch_c) begin
            wb_dat_o <= rd_sel_c;
        end
    end

    // Bank interrupt: OR of all channel requests, registered.
    always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
        if (!wb_rst_i) begin
            irq_o <= 1'b0;
        end else begin
            irq_o <= |ch_irq_c;
        end
    end

endmodule

// File: tb/tb_wb_gpio_bank.sv
// Scoreboard bench for wb_gpio_bank with a register-level reference model.
module tb_wb_gpio_bank;

    localparam logic [31:0] BASE = 32'h3000_0000;
    localparam int NCH = 4;
    localparam int CW  = 16;
    localparam int PW  = NCH * CW;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [31:0]   wb_adr_i;
    logic [31:0]   wb_dat_i;
    logic [3:0]    wb_sel_i;
    logic          wb_we_i;
    logic          wb_cyc_i;
    logic          wb_stb_i;
    logic [31:0]   wb_dat_o;
    logic          wb_ack_o;
    logic          hit_o;
    logic [PW-1:0] gpio_i;
    logic [PW-1:0] gpio_o;
    logic [PW-1:0] gpio_oe;
    logic          irq_o;

    wb_gpio_bank #(
        .BASE_ADDR (BASE),
        .NUM_CH    (NCH),
        .CH_WIDTH  (CW)
    ) dut (
        .wb_clk_i (clk),
        .wb_rst_i (rst_n),
        .wb_adr_i (wb_adr_i),
        .wb_dat_i (wb_dat_i),
        .wb_sel_i (wb_sel_i),
        .wb_we_i  (wb_we_i),
        .wb_cyc_i (wb_cyc_i),
        .wb_stb_i (wb_stb_i),
        .wb_dat_o (wb_dat_o),
        .wb_ack_o (wb_ack_o),
        .hit_o    (hit_o),
        .gpio_i   (gpio_i),
        .gpio_o   (gpio_o),
        .gpio_oe  (gpio_oe),
        .irq_o    (irq_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int unsigned cyc_cnt = 0;

    always @(posedge clk) cyc_cnt++;

    typedef struct {
        bit          is_read;
        logic [31:0] exp;
        int unsigned issue;
        string       name;
    } exp_t;

    exp_t sb[$];

    // Reference model: register contents per channel and the settled pad value.
    logic [CW-1:0] m_out  [NCH];
    logic [CW-1:0] m_dir  [NCH];
    logic [CW-1:0] m_ien  [NCH];
    logic [CW-1:0] m_edge [NCH];
    logic [CW-1:0] m_stat [NCH];
    logic [PW-1:0] m_pad;
    logic [31:0]   last_rd;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic void m_reset();
        for (int c = 0; c < NCH; c++) begin
            m_out[c] = '0; m_dir[c] = '0; m_ien[c] = '0; m_edge[c] = '0; m_stat[c] = '0;
        end
        last_rd = '0;
    endfunction

    function automatic logic [31:0] m_read(input int ch, input int ofs);
        case (ofs)
            0: return 32'(m_out[ch]);
            1: return 32'(m_dir[ch]);
            2: return 32'(m_pad[ch*CW +: CW]);
            3: return 32'(m_ien[ch]);
            4: return 32'(m_edge[ch]);
            5: return 32'(m_stat[ch]);
            default: return 32'h0;
        endcase
    endfunction

    function automatic void m_write(input int ch, input int ofs, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] m;
        logic [CW-1:0] m16;
        logic [CW-1:0] d16;
        m = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
        m16 = CW'(m);
        d16 = CW'(d & m);
        case (ofs)
            0: m_out[ch]  = (m_out[ch]  & ~m16) | d16;
            1: m_dir[ch]  = (m_dir[ch]  & ~m16) | d16;
            3: m_ien[ch]  = (m_ien[ch]  & ~m16) | d16;
            4: m_edge[ch] = (m_edge[ch] & ~m16) | d16;
            5: m_stat[ch] = m_stat[ch] & ~d16;
            default: ;
        endcase
    endfunction

    // Pads moved from m_pad to nv: record qualifying edges in STAT.
    function automatic void m_pad_move(input logic [PW-1:0] nv);
        logic [CW-1:0] o, n, r, f;
        for (int c = 0; c < NCH; c++) begin
            o = m_pad[c*CW +: CW];
            n = nv[c*CW +: CW];
            r = n & ~o;
            f = ~n & o;
            m_stat[c] = m_stat[c] | (((r & m_edge[c]) | (f & ~m_edge[c])) & m_ien[c]);
        end
        m_pad = nv;
    endfunction

    function automatic logic m_irq();
        logic x;
        x = 1'b0;
        for (int c = 0; c < NCH; c++) x = x | (|(m_stat[c] & m_ien[c]));
        return x;
    endfunction

    // Monitor: every ack pops one expectation and checks latency and read data.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && wb_ack_o) begin
            if (sb.size() == 0) begin
                check("unexpected_ack", wb_ack_o, 1'b0);
            end else begin
                e = sb.pop_front();
                check({e.name, "_latency"}, 64'(cyc_cnt - e.issue), 64'd1);
                if (e.is_read) check(e.name, wb_dat_o, e.exp);
            end
        end
    end

    task automatic bus_idle();
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
        wb_adr_i = '0; wb_dat_i = '0; wb_sel_i = '0;
    endtask

    // One bus access, called #1 after a rising edge; returns after the ack cycle.
    task automatic bus(input bit we, input int ch, input int ofs, input logic [31:0] d,
                       input logic [3:0] s, input string name);
        exp_t e;
        int n;
        bit in_win;
        in_win = (ch < NCH);
        wb_adr_i = BASE + 32'(ch * 32 + ofs * 4);
        wb_dat_i = d; wb_sel_i = s; wb_we_i = we;
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
        if (in_win) begin
            e.is_read = !we;
            e.exp     = m_read(ch, ofs);
            e.issue   = cyc_cnt;
            e.name    = name;
            sb.push_back(e);
            if (!we) last_rd = e.exp;
        end
        #1;
        check({name, "_hit"}, hit_o, in_win);
        if (in_win) begin
            n = 0;
            do begin
                @(posedge clk); #1; n++;
            end while (!wb_ack_o && n < 20);
            if (!wb_ack_o) begin
                check({name, "_ack_timeout"}, wb_ack_o, 1'b1);
                sb.delete();
            end else begin
                @(posedge clk); #1;
            end
            if (we) m_write(ch, ofs, d, s);
        end else begin
            repeat (3) begin
                @(posedge clk); #1;
                check({name, "_noack"}, wb_ack_o, 1'b0);
            end
            check({name, "_dat_hold"}, wb_dat_o, last_rd);
        end
        bus_idle();
    endtask

    task automatic check_outputs(input string name);
        logic [PW-1:0] eo, ee;
        @(posedge clk); #1;
        for (int c = 0; c < NCH; c++) begin
            eo[c*CW +: CW] = m_out[c];
            ee[c*CW +: CW] = m_dir[c];
        end
        check({name, "_gpio_o"}, 64'(gpio_o), 64'(eo));
        check({name, "_gpio_oe"}, 64'(gpio_oe), 64'(ee));
        check({name, "_irq"}, irq_o, m_irq());
    endtask

    task automatic pad_change(input logic [PW-1:0] nv);
        gpio_i = nv;
        repeat (5) @(posedge clk);
        #1;
        m_pad_move(nv);
    endtask

    int          op, ch, ofs;
    logic [31:0] d;
    logic [3:0]  s;
    logic [PW-1:0] nv;

    initial begin
        bus_idle();
        gpio_i = '0;
        m_pad = '0;
        m_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ack", wb_ack_o, 1'b0);
        check("rst_dat", wb_dat_o, 32'h0);
        check("rst_irq", irq_o, 1'b0);
        check("rst_oe", 64'(gpio_oe), 64'h0);
        check("rst_out", 64'(gpio_o), 64'h0);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Every offset of every channel reads zero after reset.
        for (int c = 0; c < NCH; c++)
            for (int o = 0; o < 8; o++)
                bus(1'b0, c, o, 32'h0, 4'hF, $sformatf("rst_rd_c%0d_o%0d", c, o));

        // Partial-lane write to ch1 OUT.
        bus(1'b1, 1, 0, 32'hA5A5_5A5A, 4'b0011, "ch1_out_wr");
        bus(1'b0, 1, 0, 32'h0, 4'hF, "ch1_out_rd");
        check("ch1_gpio_o_slice", 64'(gpio_o[2*CW-1:CW]), 64'h5A5A);
        check_outputs("ch1_out");

        // Rising edge on ch0 bit 0 raises STAT and irq within four clocks.
        bus(1'b1, 0, 3, 32'h1, 4'hF, "ch0_ien_wr");
        bus(1'b1, 0, 4, 32'h1, 4'hF, "ch0_edge_wr");
        @(posedge clk); #1;
        gpio_i[0] = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        m_pad_move(gpio_i);
        check("ch0_irq_4clk", irq_o, 1'b1);
        bus(1'b0, 0, 5, 32'h0, 4'hF, "ch0_stat_set_rd");
        bus(1'b1, 0, 5, 32'h1, 4'hF, "ch0_stat_w1c");
        check_outputs("ch0_after_w1c");
        bus(1'b0, 0, 5, 32'h0, 4'hF, "ch0_stat_clr_rd");

        // Falling edge on ch2 bit 7 coincides with a W1C of that bit: set wins.
        bus(1'b1, 2, 3, 32'h80, 4'hF, "ch2_ien_wr");
        pad_change(gpio_i | (PW'(1) << (2*CW + 7)));
        @(posedge clk); #1;
        gpio_i[2*CW+7] = 1'b0;
        @(posedge clk); #1;
        bus(1'b1, 2, 5, 32'h80, 4'b0001, "ch2_stat_w1c_race");
        m_pad_move(gpio_i);
        bus(1'b0, 2, 5, 32'h0, 4'hF, "ch2_stat_race_rd");
        check_outputs("ch2_race");
        bus(1'b1, 2, 5, 32'h80, 4'b0001, "ch2_stat_w1c");
        bus(1'b0, 2, 5, 32'h0, 4'hF, "ch2_stat_clr_rd");

        // Width truncation and an access just past the window.
        bus(1'b1, 3, 1, 32'hFFFF_FFFF, 4'hF, "ch3_dir_wr");
        bus(1'b0, 3, 1, 32'h0, 4'hF, "ch3_dir_rd");
        bus(1'b0, NCH, 0, 32'h0, 4'hF, "past_window");
        check_outputs("trunc");

        // Randomised traffic against the model.
        repeat (300) begin
            op  = int'($urandom_range(0, 9));
            ch  = ($urandom_range(0, 9) == 0) ? NCH + int'($urandom_range(0, 3)) : int'($urandom_range(0, NCH-1));
            ofs = int'($urandom_range(0, 7));
            d   = $urandom;
            s   = 4'($urandom_range(0, 15));
            if (op < 4) begin
                bus(1'b1, ch, ofs, d, s, "rnd_wr");
                check_outputs("rnd_wr");
            end else if (op < 8) begin
                bus(1'b0, ch, ofs, d, s, "rnd_rd");
            end else begin
                nv = m_pad ^ ({$urandom, $urandom} & {$urandom, $urandom});
                pad_change(nv);
                check_outputs("rnd_pad");
            end
        end

        // Reset mid-transfer with an interrupt pending.
        bus(1'b1, 3, 3, 32'h1, 4'hF, "ch3_ien_wr");
        bus(1'b1, 3, 4, 32'h1, 4'hF, "ch3_edge_wr");
        if (m_pad[3*CW]) pad_change(m_pad & ~(PW'(1) << (3*CW)));
        pad_change(m_pad | (PW'(1) << (3*CW)));
        check_outputs("pre_reset");
        check("pre_reset_irq", irq_o, 1'b1);
        wb_adr_i = BASE + 32'(3 * 32);
        wb_dat_i = 32'h0000_1234; wb_sel_i = 4'hF; wb_we_i = 1'b1;
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
        @(posedge clk); #1;
        check("mid_ack_high", wb_ack_o, 1'b1);
        #1 rst_n = 1'b0;
        #1;
        check("mid_ack_drop", wb_ack_o, 1'b0);
        check("mid_irq_clr", irq_o, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        bus_idle();
        m_reset();
        rst_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        bus(1'b0, 3, 0, 32'h0, 4'hF, "post_rst_out");
        bus(1'b0, 3, 5, 32'h0, 4'hF, "post_rst_stat");
        check_outputs("post_rst");

        repeat (3) @(posedge clk);
        check("sb_drained", 64'(sb.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Global watchdog.
    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

endmodule
